// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM arbiter and the raster fetch logic.
package vram_pkg;
   localparam int VRAM_AW = 16;
   localparam int VRAM_DW = 16;

   typedef enum logic {
      OWN_DISP = 1'b0,
      OWN_CPU  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;
endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Shift register of read-ownership tags; the tail lines up with returning VRAM read data.
module vram_rd_tag_pipe
   import vram_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  tag_t i_tag,
   output tag_t o_tag
);

   tag_t [DEPTH-1:0] r_pipe;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe <= {r_pipe[DEPTH-2:0], i_tag};
      end
   end

   assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, CPU gets a forced slot after
// CPU_MAX_WAIT refusals. One access per cycle, read data routed back by owner tag.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int AW           = VRAM_AW,
   parameter int DW           = VRAM_DW,
   parameter int RD_LAT       = 2,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          disp_req_i,
   input  logic [AW-1:0] disp_addr_i,
   output logic          disp_gnt_o,
   output logic          disp_rvalid_o,
   output logic [DW-1:0] disp_rdata_o,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_gnt_o,
   output logic          cpu_rvalid_o,
   output logic [DW-1:0] cpu_rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   localparam int             WCW      = $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WCW-1:0] MAX_WAIT = WCW'(CPU_MAX_WAIT);

   logic [WCW-1:0] r_wait_cnt;
   logic           r_mem_en;
   logic           r_mem_we;
   logic [AW-1:0]  r_mem_addr;
   logic [DW-1:0]  r_mem_wdata;
   logic           w_cpu_forced;
   logic           w_disp_gnt;
   logic           w_cpu_gnt;
   tag_t           w_tag_in;
   tag_t           w_tag_out;

   // Handshake: a transfer happens when req and gnt are high in the same cycle; the
   // requester holds address/data stable while req is high and not yet granted.
   assign w_cpu_forced = cpu_req_i && (r_wait_cnt == MAX_WAIT);
   assign w_disp_gnt   = !rst_i && disp_req_i && !w_cpu_forced;
   assign w_cpu_gnt    = !rst_i && cpu_req_i && (!disp_req_i || w_cpu_forced);

   assign disp_gnt_o = w_disp_gnt;
   assign cpu_gnt_o  = w_cpu_gnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || !cpu_req_i || w_cpu_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != MAX_WAIT) begin
         r_wait_cnt <= r_wait_cnt + WCW'(1);
      end
   end

   // Address and write data hold when idle so the macro pins stay quiet.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= w_disp_gnt || w_cpu_gnt;
         r_mem_we <= w_cpu_gnt && cpu_we_i;
         if (w_disp_gnt) begin
            r_mem_addr <= disp_addr_i;
         end else if (w_cpu_gnt) begin
            r_mem_addr  <= cpu_addr_i;
            r_mem_wdata <= cpu_wdata_i;
         end
      end
   end

   assign mem_en_o    = r_mem_en;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

   assign w_tag_in.valid = w_disp_gnt || (w_cpu_gnt && !cpu_we_i);
   assign w_tag_in.owner = w_cpu_gnt ? OWN_CPU : OWN_DISP;

   vram_rd_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_tag_pipe (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );

   assign disp_rvalid_o = !rst_i && w_tag_out.valid && (w_tag_out.owner == OWN_DISP);
   assign cpu_rvalid_o  = !rst_i && w_tag_out.valid && (w_tag_out.owner == OWN_CPU);
   assign disp_rdata_o  = mem_rdata_i;
   assign cpu_rdata_o   = mem_rdata_i;

endmodule
